// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file: ABI register
// indices, the default stack-pointer reset value and the index type.
package rf_pkg;

    localparam int RF_ADDR_W = 5;

    typedef logic [RF_ADDR_W-1:0] reg_idx_t;

    // ABI names for the low architectural registers
    localparam reg_idx_t REG_ZERO = reg_idx_t'(0);
    localparam reg_idx_t REG_RA   = reg_idx_t'(1);
    localparam reg_idx_t REG_SP   = reg_idx_t'(2);
    localparam reg_idx_t REG_GP   = reg_idx_t'(3);
    localparam reg_idx_t REG_TP   = reg_idx_t'(4);

    // Stack pointer comes out of reset pointing at the top of the first 4 KiB
    localparam logic [31:0] SP_RESET_DEFAULT = 32'h0000_0FFF;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking for outstanding writes.
// Issue sets a bit, writeback clears it; a set and clear on the same index
// in one cycle leaves the bit set because the younger instruction owns the
// register. Flush clears everything and overrides both. The pending count
// is kept incrementally so it always equals the number of set busy bits.
module rf_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [ADDR_W-1:0]     set_idx,
    input  logic                  clr_en,
    input  logic [ADDR_W-1:0]     clr_idx,
    input  logic                  flush,
    output logic [2**ADDR_W-1:0]  busy,
    output logic [ADDR_W:0]       pending_count
);

    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     count_d;
    logic                set_v;
    logic                clr_v;
    logic                same_idx;

    // Next busy vector and count from set/clear/flush priority
    always_comb begin
        set_v    = set_en && (set_idx != '0);
        clr_v    = clr_en && (clr_idx != '0);
        same_idx = (set_idx == clr_idx);
        busy_d   = busy_q;
        count_d  = count_q;

        if (clr_v) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_v) begin
            busy_d[set_idx] = 1'b1;
        end

        // A set only counts if the register was idle; a clear only counts if
        // it was busy and no younger issue re-claimed the same register.
        if (set_v && !busy_q[set_idx]) begin
            count_d = count_d + CNT_ONE;
        end
        if (clr_v && busy_q[clr_idx] && !(set_v && same_idx)) begin
            count_d = count_d - CNT_ONE;
        end

        if (flush) begin
            busy_d  = '0;
            count_d = '0;
        end
    end

    // Busy vector and pending count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy          = busy_q;
    assign pending_count = count_q;

endmodule : rf_scoreboard

// File: rtl/register_file_sb.sv
// Integer register file with a write-tracking scoreboard.
// NUM_RD combinational read ports, one write port, register 0 hardwired to
// zero, stack-pointer register with a configurable reset value.
// Optional feature macro RF_BYPASS_EN: when defined, a write is forwarded to
// any read port addressing the same non-zero register in the same cycle and
// that port's busy flag is masked. When undefined, reads see the old value
// until the cycle after the write.
module register_file_sb
    import rf_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 5,
    parameter int          NUM_RD   = 2,
    parameter int          SP_IDX   = int'(REG_SP),
    parameter logic [31:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Reg_Write_i,
    input  logic [ADDR_W-1:0]          Write_Register_i,
    input  logic [DATA_W-1:0]          Write_Data_i,
    input  logic [NUM_RD*ADDR_W-1:0]   Read_Register_i,
    output logic [NUM_RD*DATA_W-1:0]   Read_Data_o,
    output logic [NUM_RD-1:0]          Read_Busy_o,
    input  logic                       Issue_i,
    input  logic [ADDR_W-1:0]          Issue_Register_i,
    input  logic                       Flush_i,
    output logic [ADDR_W:0]            Pending_Count_o,
    output logic                       All_Clear_o
);

    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [DATA_W-1:0] SP_RESET_VAL = DATA_W'(SP_RESET);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr_v;

    assign wr_v = Reg_Write_i && (Write_Register_i != '0);

    // Register storage; reset loads zeros plus the stack-pointer value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET_VAL : '0;
            end
        end else if (wr_v) begin
            regs[Write_Register_i] <= Write_Data_i;
        end
    end

    rf_scoreboard #(
        .ADDR_W        (ADDR_W)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .set_en        (Issue_i),
        .set_idx       (Issue_Register_i),
        .clr_en        (Reg_Write_i),
        .clr_idx       (Write_Register_i),
        .flush         (Flush_i),
        .busy          (busy),
        .pending_count (Pending_Count_o)
    );

    assign All_Clear_o = (Pending_Count_o == '0);

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] rd_idx;
            logic              rd_zero;
            logic              byp_hit;
            logic [DATA_W-1:0] rd_data;
            logic              rd_busy;

            assign rd_idx  = Read_Register_i[k*ADDR_W +: ADDR_W];
            assign rd_zero = (rd_idx == '0);
`ifdef RF_BYPASS_EN
            assign byp_hit = wr_v && (Write_Register_i == rd_idx);
`else
            assign byp_hit = 1'b0;
`endif

            // Port mux: zero register, forwarded write, or stored value
            always_comb begin
                rd_data = '0;
                rd_busy = 1'b0;
                if (!rd_zero) begin
                    if (byp_hit) begin
                        rd_data = Write_Data_i;
                        rd_busy = 1'b0;
                    end else begin
                        rd_data = regs[rd_idx];
                        rd_busy = busy[rd_idx];
                    end
                end
            end

            assign Read_Data_o[k*DATA_W +: DATA_W] = rd_data;
            assign Read_Busy_o[k]                  = rd_busy;
        end
    endgenerate

endmodule : register_file_sb

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: directed scenarios followed by
// randomized traffic, compared against an array-based reference model.
module tb_register_file_sb;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            we;
    logic [AW-1:0]   wreg;
    logic [DW-1:0]   wdata;
    logic [NR*AW-1:0] rreg;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]   rbusy;
    logic            iss;
    logic [AW-1:0]   ireg;
    logic            flush;
    logic [AW:0]     pcnt;
    logic            aclr;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_regs [NREG];
    bit            m_busy [NREG];

    always #5 clk = ~clk;

    register_file_sb dut (
        .clk              (clk),
        .reset            (reset),
        .Reg_Write_i      (we),
        .Write_Register_i (wreg),
        .Write_Data_i     (wdata),
        .Read_Register_i  (rreg),
        .Read_Data_o      (rdata),
        .Read_Busy_o      (rbusy),
        .Issue_i          (iss),
        .Issue_Register_i (ireg),
        .Flush_i          (flush),
        .Pending_Count_o  (pcnt),
        .All_Clear_o      (aclr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = (i == 2) ? 32'h0000_0FFF : 32'h0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    // Architectural effect of one clock edge with the currently driven inputs
    function automatic void m_apply();
        if (we && wreg != 0) m_regs[wreg] = wdata;
        if (flush) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end else begin
            if (we && wreg != 0) m_busy[wreg] = 1'b0;
            if (iss && ireg != 0) m_busy[ireg] = 1'b1;
        end
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] idx;
            logic [DW-1:0] exp_d;
            logic          exp_b;
            bit            hit;
            idx = rreg[k*AW +: AW];
`ifdef RF_BYPASS_EN
            hit = we && (wreg == idx) && (idx != 0);
`else
            hit = 1'b0;
`endif
            if (idx == 0) begin
                exp_d = '0; exp_b = 1'b0;
            end else if (hit) begin
                exp_d = wdata; exp_b = 1'b0;
            end else begin
                exp_d = m_regs[idx]; exp_b = m_busy[idx];
            end
            check($sformatf("%s rd%0d data", tag, k), 64'(rdata[k*DW +: DW]), 64'(exp_d));
            check($sformatf("%s rd%0d busy", tag, k), 64'(rbusy[k]), 64'(exp_b));
        end
        check($sformatf("%s count", tag), 64'(pcnt), 64'(m_count()));
        check($sformatf("%s all_clear", tag), 64'(aclr), 64'(m_count() == 0));
    endtask

    task automatic drive(input logic w, input int wr, input logic [DW-1:0] wd,
                         input logic is, input int ir, input logic fl,
                         input int r0, input int r1);
        we    = w;
        wreg  = AW'(wr);
        wdata = wd;
        iss   = is;
        ireg  = AW'(ir);
        flush = fl;
        rreg  = {AW'(r1), AW'(r0)};
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        m_apply();
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp_byp;

        // Reset and read
        reset = 1'b1;
        m_reset();
        drive(0, 0, '0, 0, 0, 0, 2, 5);
        #2;
        check_all("reset");
        check("reset sp", 64'(rdata[DW-1:0]), 64'h0000_0FFF);
        check("reset r5", 64'(rdata[2*DW-1:DW]), 64'h0);
        check("reset count", 64'(pcnt), 64'h0);
        check("reset all_clear", 64'(aclr), 64'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // x0 protection
        drive(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        check_all("x0 write");
        step();
        drive(0, 0, '0, 1, 0, 0, 0, 0);
        check_all("x0 issue");
        step();
        drive(0, 0, '0, 0, 0, 0, 0, 0);
        check_all("x0 after");
        check("x0 data", 64'(rdata[DW-1:0]), 64'h0);
        check("x0 busy", 64'(rbusy), 64'h0);
        check("x0 count", 64'(pcnt), 64'h0);

        // Write forwarding
        drive(1, 7, 32'h1234_5678, 0, 0, 0, 0, 7);
`ifdef RF_BYPASS_EN
        exp_byp = 32'h1234_5678;
`else
        exp_byp = 32'h0;
`endif
        check_all("bypass same");
        check("bypass same rd1", 64'(rdata[2*DW-1:DW]), 64'(exp_byp));
        step();
        drive(0, 0, '0, 0, 0, 0, 7, 7);
        check_all("bypass next");
        check("bypass next rd0", 64'(rdata[DW-1:0]), 64'h1234_5678);
        check("bypass next rd1", 64'(rdata[2*DW-1:DW]), 64'h1234_5678);

        // Scoreboard set/clear
        drive(0, 0, '0, 1, 5, 0, 5, 6);
        step();
        drive(0, 0, '0, 1, 6, 0, 5, 6);
        step();
        drive(0, 0, '0, 0, 0, 0, 5, 6);
        check_all("sb two");
        check("sb two count", 64'(pcnt), 64'd2);
        check("sb busy5", 64'(rbusy[0]), 64'h1);
        drive(1, 5, 32'hAAAA_0005, 0, 0, 0, 5, 6);
        check_all("sb write5");
        step();
        drive(0, 0, '0, 0, 0, 0, 5, 6);
        check_all("sb after5");
        check("sb one count", 64'(pcnt), 64'd1);
        drive(1, 6, 32'hAAAA_0006, 1, 6, 0, 5, 6);
        check_all("sb setclr");
        step();
        drive(0, 0, '0, 0, 0, 0, 5, 6);
        check_all("sb setwins");
        check("sb busy6", 64'(rbusy[1]), 64'h1);
        check("sb setwins count", 64'(pcnt), 64'd1);

        // Flush overrides a simultaneous issue
        drive(0, 0, '0, 1, 3, 0, 3, 4);
        step();
        drive(0, 0, '0, 1, 4, 0, 3, 4);
        step();
        drive(0, 0, '0, 1, 9, 0, 9, 10);
        step();
        drive(0, 0, '0, 0, 0, 0, 3, 9);
        check_all("flush pre");
        check("flush pre count", 64'(pcnt), 64'd4);
        drive(0, 0, '0, 1, 10, 1, 9, 10);
        step();
        drive(0, 0, '0, 0, 0, 0, 9, 10);
        check_all("flush post");
        check("flush count", 64'(pcnt), 64'd0);
        check("flush all_clear", 64'(aclr), 64'h1);
        check("flush busy", 64'(rbusy), 64'h0);

        // Asynchronous reset between edges discards the pending write
        drive(1, 8, 32'hCAFE_0008, 1, 11, 0, 8, 11);
        step();
        drive(0, 0, '0, 1, 8, 0, 8, 11);
        step();
        drive(1, 8, 32'h5555_5555, 0, 0, 0, 8, 11);
        check_all("async pre");
        #2;
        reset = 1'b1;
        m_reset();
        drive(0, 0, '0, 0, 0, 0, 8, 11);
        check_all("async in");
        check("async r8", 64'(rdata[DW-1:0]), 64'h0);
        check("async busy", 64'(rbusy), 64'h0);
        check("async count", 64'(pcnt), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_all("async out");

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            int hi;
            hi = ($urandom_range(0, 3) == 0) ? 31 : 12;
            drive(logic'($urandom_range(0, 1)), $urandom_range(0, hi), $urandom,
                  logic'($urandom_range(0, 1)), $urandom_range(0, hi),
                  logic'($urandom_range(0, 31) == 0),
                  $urandom_range(0, hi), $urandom_range(0, hi));
            check_all($sformatf("rand%0d", n));
            step();
        end
        drive(0, 0, '0, 0, 0, 0, 1, 2);
        check_all("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_register_file_sb
